// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// It combines the hazard-unit stall, EX redirects, data-memory waits, fetch
// readiness and halt/resume into per-stage enables and flushes. It also runs a
// memory-timeout watchdog and keeps saturating performance counters.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_hz_stall          load-use / WB stall from hazard_unit
//   i_br_redirect       EX-stage taken branch or jump
//   i_dmem_req/ack      MEM-stage access pending / completing
//   i_imem_ready        fetched instruction valid
//   i_halt, i_resume    ebreak in WB / leave-halt pulse
//   o_pc_en, o_*_en     PC and pipeline register enables
//   o_*_flush           load a bubble (overrides the matching enable)
//   o_halted, o_fault   FSM status
//   o_stall_cycles      saturating count of PC-stalled RUN/MEM_WAIT cycles
//   o_redirects         saturating count of applied redirects
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | data memory access outstanding, pipeline frozen
// HALT     | ebreak retired, waiting for i_resume
// FAULT    | memory access timed out, only i_reset leaves

module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hz_stall,
    input  logic             i_br_redirect,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    input  logic             i_imem_ready,
    input  logic             i_halt,
    input  logic             i_resume,
    output logic             o_pc_en,
    output logic             o_IF_ID_en,
    output logic             o_ID_EX_en,
    output logic             o_EX_MEM_en,
    output logic             o_MEM_WB_en,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_flush,
    output logic             o_MEM_WB_flush,
    output logic             o_halted,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_redirects
);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] redir_q, redir_d;

    logic run_eval;
    logic mem_busy;
    logic redir_applied;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        stall_d        = stall_q;
        redir_d        = redir_q;
        run_eval       = 1'b0;
        mem_busy       = 1'b0;
        redir_applied  = 1'b0;
        o_pc_en        = 1'b0;
        o_IF_ID_en     = 1'b0;
        o_ID_EX_en     = 1'b0;
        o_EX_MEM_en    = 1'b0;
        o_MEM_WB_en    = 1'b0;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_MEM_WB_flush = 1'b0;
        o_halted       = 1'b0;
        o_fault        = 1'b0;

        case (state_q)
            S_RUN: begin
                run_eval = 1'b1;
                mem_busy = i_dmem_req & ~i_dmem_ack;
            end
            S_MEM_WAIT: begin
                if (i_dmem_ack) begin
                    // Completing cycle behaves like a normal RUN cycle.
                    run_eval = 1'b1;
                end else begin
                    o_MEM_WB_en    = 1'b1;
                    o_MEM_WB_flush = 1'b1;
                    if (wait_q == TIMEOUT) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end
            S_HALT: begin
                o_halted = 1'b1;
                if (i_resume) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                o_fault = 1'b1;
            end
        endcase

        if (run_eval) begin
            if (mem_busy) begin
                // EX stays frozen, so any redirect/stall is re-presented later.
                o_MEM_WB_en    = 1'b1;
                o_MEM_WB_flush = 1'b1;
                state_d        = S_MEM_WAIT;
                wait_d         = 16'd1;
            end else if (i_halt) begin
                // Bubble behind the ebreak so it retires exactly once.
                o_MEM_WB_flush = 1'b1;
                state_d        = S_HALT;
            end else begin
                o_pc_en     = 1'b1;
                o_IF_ID_en  = 1'b1;
                o_ID_EX_en  = 1'b1;
                o_EX_MEM_en = 1'b1;
                o_MEM_WB_en = 1'b1;
                state_d     = S_RUN;
                if (i_br_redirect) begin
                    // The stalled instruction is squashed, so the stall is moot.
                    o_IF_ID_flush = 1'b1;
                    o_ID_EX_flush = 1'b1;
                    redir_applied = 1'b1;
                end else if (i_hz_stall) begin
                    o_pc_en       = 1'b0;
                    o_IF_ID_en    = 1'b0;
                    o_ID_EX_flush = 1'b1;
                end else if (!i_imem_ready) begin
                    o_pc_en       = 1'b0;
                    o_IF_ID_flush = 1'b1;
                end
            end
        end

        if ((state_q == S_RUN || state_q == S_MEM_WAIT) && !o_pc_en && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
        if (redir_applied && redir_q != CNT_MAX) begin
            redir_d = redir_q + 1'b1;
        end

        if (i_reset) begin
            o_pc_en        = 1'b0;
            o_IF_ID_en     = 1'b0;
            o_ID_EX_en     = 1'b0;
            o_EX_MEM_en    = 1'b0;
            o_MEM_WB_en    = 1'b0;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_MEM_WB_flush = 1'b1;
            o_halted       = 1'b0;
            o_fault        = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            redir_q <= redir_d;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_redirects    = redir_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, hz, br, req, ack, imem, halt, resume;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush, halted, fault;
    logic [3:0] stall_cnt, redir_cnt;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_hz_stall(hz), .i_br_redirect(br),
        .i_dmem_req(req), .i_dmem_ack(ack), .i_imem_ready(imem),
        .i_halt(halt), .i_resume(resume),
        .o_pc_en(pc_en), .o_IF_ID_en(if_id_en), .o_ID_EX_en(id_ex_en),
        .o_EX_MEM_en(ex_mem_en), .o_MEM_WB_en(mem_wb_en),
        .o_IF_ID_flush(if_id_flush), .o_ID_EX_flush(id_ex_flush),
        .o_MEM_WB_flush(mem_wb_flush), .o_halted(halted), .o_fault(fault),
        .o_stall_cycles(stall_cnt), .o_redirects(redir_cnt)
    );

    // ctl = {pc, if_id, id_ex, ex_mem, mem_wb en | if_id, id_ex, mem_wb flush | halted, fault}
    localparam logic [9:0] C_RUN   = 10'b11111_000_00;
    localparam logic [9:0] C_RST   = 10'b00000_111_00;
    localparam logic [9:0] C_MEM   = 10'b00001_001_00;
    localparam logic [9:0] C_HIN   = 10'b00000_001_00;
    localparam logic [9:0] C_HLT   = 10'b00000_000_10;
    localparam logic [9:0] C_FLT   = 10'b00000_000_01;
    localparam logic [9:0] C_RED   = 10'b11111_110_00;
    localparam logic [9:0] C_HZ    = 10'b00111_010_00;
    localparam logic [9:0] C_NOIM  = 10'b01111_100_00;

    // in = {reset, hz, br, req, ack, imem, halt, resume}
    localparam logic [7:0] I_Q     = 8'b0000_0100;
    localparam logic [7:0] I_RST   = 8'b1000_0100;
    localparam logic [7:0] I_HZ    = 8'b0100_0100;
    localparam logic [7:0] I_HZBR  = 8'b0110_0100;
    localparam logic [7:0] I_BR    = 8'b0010_0100;
    localparam logic [7:0] I_NOIM  = 8'b0000_0000;
    localparam logic [7:0] I_REQ   = 8'b0001_0100;
    localparam logic [7:0] I_ACK   = 8'b0001_1100;
    localparam logic [7:0] I_REQBR = 8'b0011_0100;
    localparam logic [7:0] I_ACKBR = 8'b0011_1100;
    localparam logic [7:0] I_HALT  = 8'b0000_0110;
    localparam logic [7:0] I_RES   = 8'b0000_0101;
    localparam logic [7:0] I_ACKH  = 8'b0001_1110;

    typedef struct {
        int         step;
        logic [9:0] ctl;
        logic [3:0] st;
        logic [3:0] rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    task automatic drive(input logic [7:0] in);
        {reset, hz, br, req, ack, imem, halt, resume} = in;
    endtask

    task automatic step(input logic [7:0] in, input logic [9:0] ctl, input int st, input int rd);
        exp_t e;
        @(posedge clk);
        #1;
        drive(in);
        e.step = step_no;
        e.ctl  = ctl;
        e.st   = 4'(st);
        e.rd   = 4'(rd);
        sb.push_back(e);
        step_no++;
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t e;
        logic [9:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_flush, halted, fault};
                total++;
                if (got !== e.ctl) begin
                    bad++;
                    $display("FAIL step %0d ctl: got %b want %b", e.step, got, e.ctl);
                end
                total++;
                if (stall_cnt !== e.st) begin
                    bad++;
                    $display("FAIL step %0d stall_cycles: got %0d want %0d", e.step, stall_cnt, e.st);
                end
                total++;
                if (redir_cnt !== e.rd) begin
                    bad++;
                    $display("FAIL step %0d redirects: got %0d want %0d", e.step, redir_cnt, e.rd);
                end
            end
        end
    end

    initial begin
        drive(I_RST);
        @(posedge clk);
        #1;
        drive(I_RST);

        // reset with random side inputs
        for (int i = 0; i < 2; i++) step({1'b1, 7'($urandom)}, C_RST, 0, 0);
        step(I_Q,    C_RUN,  0, 0);
        // load-use, then stall+redirect (redirect wins), then missing fetch
        step(I_HZ,   C_HZ,   0, 0);
        step(I_HZBR, C_RED,  1, 0);
        step(I_Q,    C_RUN,  1, 1);
        step(I_NOIM, C_NOIM, 1, 1);
        step(I_Q,    C_RUN,  2, 1);

        // memory wait: ack three cycles after the request
        step(I_RST,  C_RST,  2, 1);
        step(I_REQ,  C_MEM,  0, 0);
        step(I_REQ,  C_MEM,  1, 0);
        step(I_REQ,  C_MEM,  2, 0);
        step(I_ACK,  C_RUN,  3, 0);
        step(I_Q,    C_RUN,  3, 0);
        // redirect during busy memory is deferred until the ack cycle
        step(I_REQBR, C_MEM, 3, 0);
        step(I_ACKBR, C_RED, 4, 0);
        step(I_Q,    C_RUN,  4, 1);

        // timeout: four MEM_WAIT cycles without ack -> FAULT
        step(I_RST,  C_RST,  4, 1);
        step(I_REQ,  C_MEM,  0, 0);
        step(I_REQ,  C_MEM,  1, 0);
        step(I_REQ,  C_MEM,  2, 0);
        step(I_REQ,  C_MEM,  3, 0);
        step(I_REQ,  C_MEM,  4, 0);
        step(I_Q,    C_FLT,  5, 0);
        step(I_RES,  C_FLT,  5, 0);
        step(I_REQ,  C_FLT,  5, 0);
        step(I_RST,  C_RST,  5, 0);
        step(I_Q,    C_RUN,  0, 0);
        // ack on the last permitted MEM_WAIT cycle wins over the timeout
        step(I_REQ,  C_MEM,  0, 0);
        step(I_REQ,  C_MEM,  1, 0);
        step(I_REQ,  C_MEM,  2, 0);
        step(I_REQ,  C_MEM,  3, 0);
        step(I_ACK,  C_RUN,  4, 0);
        step(I_Q,    C_RUN,  4, 0);

        // halt / resume
        step(I_HALT, C_HIN,  4, 0);
        step(I_Q,    C_HLT,  5, 0);
        step(I_BR,   C_HLT,  5, 0);
        step(I_RES,  C_HLT,  5, 0);
        step(I_Q,    C_RUN,  5, 0);
        step(I_RES,  C_RUN,  5, 0);
        step(I_Q,    C_RUN,  5, 0);
        // halt arriving with the memory ack
        step(I_REQ,  C_MEM,  5, 0);
        step(I_ACKH, C_HIN,  6, 0);
        step(I_Q,    C_HLT,  7, 0);
        step(I_RES,  C_HLT,  7, 0);
        step(I_Q,    C_RUN,  7, 0);

        // saturation of both counters at 15
        step(I_RST,  C_RST,  7, 0);
        for (int i = 0; i < 20; i++) step(I_BR, C_RED, 0, (i > 15) ? 15 : i);
        step(I_Q,    C_RUN,  0, 15);
        for (int i = 0; i < 17; i++) step(I_HZ, C_HZ, (i > 15) ? 15 : i, 15);
        step(I_Q,    C_RUN,  15, 15);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges the hazard unit's stall request, EX-stage branch/jump redirects, multi-cycle data-memory waits, instruction-fetch readiness and halt/resume into per-stage register enables and flushes. It contains a small FSM for memory-wait, halt and fault sequencing, a memory-timeout watchdog and saturating performance counters. It sits beside hazard_unit and drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.

Parameters:
MEM_TIMEOUT, 255, maximum consecutive cycles in MEM_WAIT before entering FAULT (1..2^16-1).
CNT_W, 16, width of the performance counters.

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_reset  input  1  synchronous, active-high reset
i_hz_stall  input  1  load-use/WB stall request from hazard_unit (its o_IF_ID_stall)
i_br_redirect  input  1  EX-stage taken branch or jump; PC loads the target this cycle
i_dmem_req  input  1  MEM stage holds a load or store
i_dmem_ack  input  1  data memory completes the MEM-stage access this cycle
i_imem_ready  input  1  fetched instruction valid this cycle
i_halt  input  1  WB stage holds ebreak
i_resume  input  1  single-cycle pulse that leaves HALT
o_pc_en  output  1  PC register enable
o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en  output  1 each  pipeline register enables
o_IF_ID_flush, o_ID_EX_flush, o_MEM_WB_flush  output  1 each  load a bubble (NOP, wren=0) into the register
o_halted  output  1  FSM in HALT
o_fault  output  1  FSM in FAULT
o_stall_cycles  output  CNT_W  saturating count of cycles with o_pc_en=0 in RUN or MEM_WAIT
o_redirects  output  CNT_W  saturating count of applied redirects

Behaviour:
- Clock is i_clk; reset is synchronous, active-high on i_reset.
- While i_reset=1: FSM goes to RUN, the wait counter and both perf counters go to 0, and o_halted=o_fault=0. All *_en=0 and all *_flush=1.
- Outputs are combinational from the FSM state and the inputs. Flush takes precedence over en: a register with flush=1 loads the bubble whether or not its en is set.
- FSM states: RUN, MEM_WAIT, HALT, FAULT.
- RUN conditions are evaluated in the priority order below; the default is every en=1 and every flush=0.
  1. mem_busy = i_dmem_req & ~i_dmem_ack:
     - o_pc_en, o_IF_ID_en, o_ID_EX_en and o_EX_MEM_en are 0.
     - o_MEM_WB_flush=1.
     - Next state is MEM_WAIT with the wait counter set to 1.
     - A redirect or hazard stall in the same cycle is not applied; EX is frozen, so it is re-presented later.
  2. i_halt:
     - All en=0 and o_MEM_WB_flush=1, so the ebreak retires exactly once.
     - Next state is HALT.
  3. i_br_redirect:
     - All en=1, o_IF_ID_flush=1 and o_ID_EX_flush=1.
     - o_redirects increments.
     - This overrides i_hz_stall, because the stalled instruction is squashed.
  4. i_hz_stall:
     - o_pc_en=0, o_IF_ID_en=0 and o_ID_EX_flush=1.
     - EX/MEM and MEM/WB stay enabled.
  5. ~i_imem_ready:
     - o_pc_en=0 and o_IF_ID_flush=1.
     - The downstream stages advance.
- MEM_WAIT:
  - While ~i_dmem_ack, outputs are the same as RUN case 1 and the wait counter increments.
  - When the wait counter reaches MEM_TIMEOUT with no ack, next state is FAULT.
  - When i_dmem_ack=1, this cycle's outputs are computed exactly as in RUN with mem_busy forced to 0, and next state is RUN (or HALT if i_halt=1).
  - An ack in the same cycle the counter reaches MEM_TIMEOUT wins; next state is RUN.
- HALT:
  - All en=0, all flush=0, o_halted=1.
  - i_resume gives next state RUN; the resume cycle itself stays frozen.
  - i_resume outside HALT is ignored.
- FAULT:
  - All en=0, o_fault=1.
  - Only i_reset exits.
- Counters:
  - o_stall_cycles increments by 1 on each RUN or MEM_WAIT cycle where o_pc_en=0.
  - Both counters hold at 2^CNT_W-1 and never wrap.
  - Both are frozen in HALT and FAULT.
- Latency: control is zero-cycle (combinational). State changes take effect on the next edge.

Test Plan:
- Reset: hold i_reset for 2 cycles with random inputs -> all en=0, all flush=1, counters 0, o_halted=o_fault=0. On the first cycle after release with quiet inputs and i_imem_ready=1 -> all en=1, all flush=0.
- Load-use: i_hz_stall=1 for 1 cycle -> o_pc_en=0, o_IF_ID_en=0, o_ID_EX_flush=1, o_stall_cycles=1. Then i_hz_stall=1 together with i_br_redirect=1 -> redirect wins: o_IF_ID_flush=o_ID_EX_flush=1, o_pc_en=1, o_redirects=1.
- Memory wait: i_dmem_req=1 with ack arriving 3 cycles later -> 3 frozen cycles with o_MEM_WB_flush=1, then a RUN cycle with all en=1. o_stall_cycles=3.
- Timeout: MEM_TIMEOUT=4 and i_dmem_req=1 with no ack -> o_fault=1 after cycle 4, all en=0 persisting. i_reset clears the fault. Rerun with ack on cycle 4 -> back in RUN, no fault.
- Halt/resume: i_halt=1 -> o_halted=1 next cycle and all en=0 while halted. i_resume pulse -> o_halted=0 the following cycle. A stray i_resume in RUN has no effect.
- Saturation: CNT_W=4 with 20 redirect cycles -> o_redirects=15 and holds.
